// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Default register address width of the core.
  localparam int REG_AW = 5;

  // Encoding of a bubble instruction loaded by a flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Scheduler state encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags a load in EX whose destination feeds the instruction in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the scheduler in the same cycle.
module pipeline_hazard_ctrl_hazard_detect #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          ex_memread,
  input  logic [AW-1:0] ex_rt,
  output logic          load_use
);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, taken-branch and data-memory wait states.
// Latency: controls are combinational from registered state, so stalls/flushes act in the same cycle.
// Backpressure: dmem_ready_i low freezes the pipe (up to MEM_TIMEOUT cycles, then HALT); optional counters via HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  output logic              pc_write_o,
  output logic              if_id_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_stall_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_stall_o,
  output logic              mem_wb_flush_o,
  output logic              busy_o,
  output logic              err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       memwait_cnt_o
`endif
);

  import pipeline_hazard_ctrl_pkg::*;

  // Last wait count before the timeout fires, and the saturated value held afterwards.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             load_use;
  logic             mem_hold;
  logic             lu_stall;
  logic             br_flush;

  pipeline_hazard_ctrl_hazard_detect #(
    .AW (REG_AW)
  ) u_hazard_detect (
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .ex_memread (ex_memread_i),
    .ex_rt      (ex_rt_i),
    .load_use   (load_use)
  );

  // Output decode: memory freeze beats load-use, which beats a taken branch.
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    busy_o         = 1'b0;
    mem_hold       = 1'b0;
    lu_stall       = 1'b0;
    br_flush       = 1'b0;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        busy_o = 1'b1;
        // In MEM_WAIT only ready matters; in RUN a zero-wait access (req and ready) is not a stall.
        if (state == ST_MEM_WAIT) mem_hold = !dmem_ready_i;
        else                      mem_hold = dmem_req_i && !dmem_ready_i;
        if (mem_hold) begin
          if_id_stall_o  = 1'b1;
          id_ex_stall_o  = 1'b1;
          ex_mem_stall_o = 1'b1;
          mem_wb_flush_o = 1'b1;
        end else if (load_use) begin
          // The branch, if any, re-resolves once the bubble has been inserted.
          lu_stall      = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else begin
          br_flush      = branch_taken_i;
          pc_write_o    = 1'b1;
          if_id_flush_o = branch_taken_i;
        end
      end
      default: begin
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
      end
    endcase
  end

  // Scheduler state, data-memory wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) state <= ST_RUN;
        end
        ST_RUN: begin
          // An access that starts waiting is finished even if start_i drops.
          if (dmem_req_i && !dmem_ready_i) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= TMO_W'(1);
          end else if (!start_i) begin
            state <= ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= TMO_LAST) begin
            state    <= ST_HALT;
            wait_cnt <= TMO_MAX;
            err_o    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Event counters; they only see events in RUN/MEM_WAIT so they freeze in IDLE and HALT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      memwait_cnt_o <= '0;
    end else begin
      if ((state == ST_RUN) && lu_stall) stall_cnt_o   <= stall_cnt_o + 32'd1;
      if (br_flush)                      flush_cnt_o   <= flush_cnt_o + 32'd1;
      if (state == ST_MEM_WAIT)          memwait_cnt_o <= memwait_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, timeout/perf sequences, random run vs reference model.
// Latency: outputs are compared mid-cycle, after inputs settle.
// Backpressure: dmem_ready_i driven low in bursts, including a forced timeout.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  // Output vector layout: {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, busy, err}
  localparam logic [8:0] O_IDLE = 9'b0_1_0_1_0_1_0_0_0;
  localparam logic [8:0] O_HALT = 9'b0_1_0_1_0_1_0_0_1;
  localparam logic [8:0] O_RUN  = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] O_LU   = 9'b0_1_0_0_1_0_0_1_0;
  localparam logic [8:0] O_BR   = 9'b1_0_1_0_0_0_0_1_0;
  localparam logic [8:0] O_MEM  = 9'b0_1_0_1_0_1_1_1_0;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] id_rs_i = '0;
  logic [4:0] id_rt_i = '0;
  logic       ex_memread_i = 1'b0;
  logic [4:0] ex_rt_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       dmem_req_i = 1'b0;
  logic       dmem_ready_i = 1'b0;
  logic       pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o;
  logic       ex_mem_stall_o, mem_wb_flush_o, busy_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(
    .REG_AW      (5),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (5)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_write_o     (pc_write_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_stall_o (ex_mem_stall_o),
    .mem_wb_flush_o (mem_wb_flush_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .memwait_cnt_o  (memwait_cnt_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "started", number of consecutive wait cycles so far, halted flag.
  int          m_started, m_waits, m_halted;
  logic [31:0] m_stall, m_flush, m_mw;

  typedef struct {
    logic       start;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [8:0] dut_out();
    return {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
            ex_mem_stall_o, mem_wb_flush_o, busy_o, err_o};
  endfunction

  function automatic logic [8:0] model_out();
    logic frozen, lu;
    if (m_halted != 0)  return O_HALT;
    if (m_started == 0) return O_IDLE;
    frozen = (m_waits > 0) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
    lu = ex_memread_i && (ex_rt_i != 5'd0) && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    if (frozen)         return O_MEM;
    if (lu)             return O_LU;
    if (branch_taken_i) return O_BR;
    return O_RUN;
  endfunction

  task automatic model_reset();
    m_started = 0; m_waits = 0; m_halted = 0;
    m_stall = '0; m_flush = '0; m_mw = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_tick();
    logic [8:0] o;
    o = model_out();
    if (m_started != 0 && m_halted == 0) begin
      if (m_waits == 0 && o == O_LU) m_stall = m_stall + 32'd1;
      if (o == O_BR)                 m_flush = m_flush + 32'd1;
      if (m_waits > 0)               m_mw    = m_mw + 32'd1;
    end
    if (m_halted != 0) begin
      // stays halted until reset
    end else if (m_started == 0) begin
      m_started = start_i ? 1 : 0;
    end else if (m_waits == 0) begin
      if (dmem_req_i && !dmem_ready_i) m_waits = 1;
      else if (!start_i)               m_started = 0;
    end else if (dmem_ready_i) begin
      m_waits = 0;
    end else begin
      m_waits = m_waits + 1;
      if (m_waits >= MEM_TIMEOUT) m_halted = 1;
    end
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %b expected %b (pcw,ifs,iff,ids,idf,exs,mwf,busy,err)",
               name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic req, input logic rdy);
    start_i = st; id_rs_i = rs; id_rt_i = rt; ex_memread_i = mr;
    ex_rt_i = ert; branch_taken_i = br; dmem_req_i = req; dmem_ready_i = rdy;
  endtask

  // One cycle: compare mid-cycle, then let the edge happen and advance the model.
  task automatic step(input string name, input logic [8:0] exp);
    @(negedge clk_i);
    check(name, dut_out(), exp);
    @(posedge clk_i);
    model_tick();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check32({name, "/stall_cnt"},   stall_cnt_o,   m_stall);
    check32({name, "/flush_cnt"},   flush_cnt_o,   m_flush);
    check32({name, "/memwait_cnt"}, memwait_cnt_o, m_mw);
`endif
  endtask

  task automatic do_reset(input string name);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    model_reset();
    #2;
    check(name, dut_out(), O_IDLE);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic add(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                     input logic mr, input logic [4:0] ert, input logic br,
                     input logic req, input logic rdy, input logic [8:0] exp);
    vec_t v;
    v.start = st; v.rs = rs; v.rt = rt; v.memread = mr; v.ex_rt = ert;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    //  st  rs     rt     mr  ex_rt  br  req rdy  expected
    for (int i = 0; i < 5; i++)
      add(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_IDLE);   // held idle after reset
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_IDLE);     // start seen at this edge
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);      // running next cycle
    add(1, 5'd8, 5'd1, 1, 5'd8, 0, 0, 0, O_LU);       // load-use on rs
    add(1, 5'd8, 5'd1, 0, 5'd8, 0, 0, 0, O_RUN);      // stall lasts one cycle
    add(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, O_RUN);      // r0 never hazards
    add(1, 5'd3, 5'd9, 1, 5'd9, 1, 0, 0, O_LU);       // load-use on rt beats branch
    add(1, 5'd3, 5'd9, 0, 5'd9, 1, 0, 0, O_BR);       // branch re-resolves
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, O_RUN);      // zero-wait access
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_MEM);      // wait 1 (RUN)
    add(1, 5'd4, 5'd0, 1, 5'd4, 1, 1, 0, O_MEM);      // wait 2, hazards ignored
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_MEM);      // wait 3
    add(1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1, O_BR);       // ready: RUN decode applies
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);      // start drops: still RUN this cycle
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_IDLE);
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_IDLE);
    add(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_MEM);      // wait beats start drop
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, O_MEM);      // MEM_WAIT not left for IDLE
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, O_RUN);
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);      // back in RUN, then IDLE
    add(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_IDLE);

    do_reset("reset_table");
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].start, tbl[i].rs, tbl[i].rt, tbl[i].memread, tbl[i].ex_rt,
             tbl[i].br, tbl[i].req, tbl[i].rdy);
      step($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Timeout: 16 wait cycles with ready low, then HALT with err until reset.
    do_reset("reset_tmo");
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    step("tmo_idle", O_IDLE);
    step("tmo_run", O_RUN);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < MEM_TIMEOUT; i++) step($sformatf("tmo_wait%0d", i + 1), O_MEM);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step($sformatf("tmo_halt%0d", i), O_HALT);
    do_reset("reset_after_halt");
    step("post_halt_idle", O_IDLE);

`ifdef HAZARD_PERF_CNT_EN
    // Two load-use stalls, one branch flush, three MEM_WAIT cycles.
    do_reset("reset_perf");
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("perf_idle", O_IDLE);
    set_in(1, 5'd6, 5'd0, 1, 5'd6, 0, 0, 0); step("perf_lu1", O_LU);
    set_in(1, 5'd0, 5'd7, 1, 5'd7, 0, 0, 0); step("perf_lu2", O_LU);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0); step("perf_br", O_BR);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("perf_wait", O_MEM);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1); step("perf_resume", O_RUN);
    set_in(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("perf_run", O_RUN);
    check32("perf_stall_total",   stall_cnt_o,   32'd2);
    check32("perf_flush_total",   flush_cnt_o,   32'd1);
    check32("perf_memwait_total", memwait_cnt_o, 32'd3);
`endif

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) do_reset("reset_rand");
      set_in($urandom_range(0, 15) != 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (c % 500 > 400) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0));
      step("rand", model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
